// File: rtl/riscv_pkg.sv
// Shared RV32I types and sizes for the integer register file.
// Pure declarations: no logic, no latency, no flow control.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      word_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: two read indices/data plus one write port.
// master drives indices and write data; slave returns read data combinationally.
interface reg_file_if;
  import riscv_pkg::*;

  reg_idx_t rsR1;
  reg_idx_t rsR2;
  reg_idx_t rsW;
  word_t    dataW;
  logic     RegWEn;
  word_t    dataR1;
  word_t    dataR2;

  modport master (
    output rsR1, rsR2, rsW, dataW, RegWEn,
    input  dataR1, dataR2
  );

  modport slave (
    input  rsR1, rsR2, rsW, dataW, RegWEn,
    output dataR1, dataR2
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port: x0 zero-detect, array select, optional write bypass.
// Zero latency; output forced to zero while reset is asserted.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter bit WRITE_THROUGH = 1'b1
) (
  input  logic     rst_n,
  input  reg_idx_t rsR,
  input  reg_idx_t rsW,
  input  word_t    dataW,
  input  logic     RegWEn,
  input  word_t    regs [1:NUM_REGS-1],
  output word_t    dataR
);

  logic bypassHit;

  if (WRITE_THROUGH) begin : gBypass
    assign bypassHit = RegWEn && (rsW != '0) && (rsW == rsR);
  end else begin : gNoBypass
    assign bypassHit = 1'b0;
  end

  // x0 is never stored, so index 0 must not reach the array select.
  always_comb begin
    dataR = '0;
    if (rst_n && (rsR != '0)) begin
      dataR = bypassHit ? dataW : regs[rsR];
    end
  end

endmodule

// File: rtl/reg_file.sv
// RV32I register file: 31 stored GPRs (x0 constant zero), two combinational reads, one write.
// Write commits on the rising edge; reset clears everything asynchronously and drops pending writes.
module reg_file
  import riscv_pkg::*;
#(
  parameter bit WRITE_THROUGH = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave rf
);

  word_t regs [1:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf.RegWEn && (rf.rsW != '0)) begin
      regs[rf.rsW] <= rf.dataW;
    end
  end

  regfile_read_port #(
    .WRITE_THROUGH (WRITE_THROUGH)
  ) uReadPort1 (
    .rst_n  (rst_n),
    .rsR    (rf.rsR1),
    .rsW    (rf.rsW),
    .dataW  (rf.dataW),
    .RegWEn (rf.RegWEn),
    .regs   (regs),
    .dataR  (rf.dataR1)
  );

  regfile_read_port #(
    .WRITE_THROUGH (WRITE_THROUGH)
  ) uReadPort2 (
    .rst_n  (rst_n),
    .rsR    (rf.rsR2),
    .rsW    (rf.rsW),
    .dataW  (rf.dataW),
    .RegWEn (rf.RegWEn),
    .regs   (regs),
    .dataR  (rf.dataR2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: one write-through and one non-bypass instance driven with identical stimulus.
module tb_reg_file;
  import riscv_pkg::*;

  logic     clk;
  logic     rst_n;
  reg_idx_t rsR1, rsR2, rsW;
  word_t    dataW;
  logic     RegWEn;

  int nChecks;
  int nFails;

  word_t model [0:31];

  reg_file_if ifWt ();
  reg_file_if ifNo ();

  assign ifWt.rsR1   = rsR1;
  assign ifWt.rsR2   = rsR2;
  assign ifWt.rsW    = rsW;
  assign ifWt.dataW  = dataW;
  assign ifWt.RegWEn = RegWEn;
  assign ifNo.rsR1   = rsR1;
  assign ifNo.rsR2   = rsR2;
  assign ifNo.rsW    = rsW;
  assign ifNo.dataW  = dataW;
  assign ifNo.RegWEn = RegWEn;

  reg_file #(.WRITE_THROUGH(1'b1)) dutWt (.clk(clk), .rst_n(rst_n), .rf(ifWt));
  reg_file #(.WRITE_THROUGH(1'b0)) dutNo (.clk(clk), .rst_n(rst_n), .rf(ifNo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view: what a read of idx must return right now.
  function automatic word_t expRead(reg_idx_t idx, bit wt);
    if (!rst_n || idx == 5'd0) return 32'h0;
    if (wt && RegWEn && rsW != 5'd0 && rsW == idx) return dataW;
    return model[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n && RegWEn && rsW != 5'd0) model[rsW] = dataW;
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RegWEn = 1'b1; rsW = 5'd3; dataW = 32'hA5A5_5A5A;
    rsR1 = 5'd3; rsR2 = 5'd3;
    clearModel();
    #1;
    nChecks++;
    if (ifWt.dataR1 !== 32'h0) begin
      nFails++; $display("FAIL reset_bypass_suppressed: got %h expected %h", ifWt.dataR1, 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; RegWEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rsR1 = 5'(i); rsR2 = 5'(31 - i);
      #1;
      nChecks++;
      if (ifWt.dataR1 !== 32'h0 || ifWt.dataR2 !== 32'h0 ||
          ifNo.dataR1 !== 32'h0 || ifNo.dataR2 !== 32'h0) begin
        nFails++;
        $display("FAIL reset_sweep idx %0d: got %h %h %h %h expected %h", i,
                 ifWt.dataR1, ifWt.dataR2, ifNo.dataR1, ifNo.dataR2, 32'h0);
      end
    end
  endtask

  task automatic test_basic_write();
    @(negedge clk);
    RegWEn = 1'b1; rsW = 5'd5; dataW = 32'h1234_5678;
    tick();
    @(negedge clk);
    RegWEn = 1'b0; rsR1 = 5'd5; rsR2 = 5'd5;
    #1;
    nChecks++;
    if (ifWt.dataR1 !== 32'h1234_5678 || ifWt.dataR2 !== 32'h1234_5678 ||
        ifNo.dataR1 !== 32'h1234_5678 || ifNo.dataR2 !== 32'h1234_5678) begin
      nFails++;
      $display("FAIL basic_write_x5: got %h %h %h %h expected %h",
               ifWt.dataR1, ifWt.dataR2, ifNo.dataR1, ifNo.dataR2, 32'h1234_5678);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    RegWEn = 1'b1; rsW = 5'd0; dataW = 32'hFFFF_FFFF; rsR1 = 5'd0; rsR2 = 5'd0;
    #1;
    nChecks++;
    if (ifWt.dataR1 !== 32'h0 || ifWt.dataR2 !== 32'h0) begin
      nFails++; $display("FAIL x0_no_bypass: got %h %h expected %h", ifWt.dataR1, ifWt.dataR2, 32'h0);
    end
    tick();
    @(negedge clk);
    RegWEn = 1'b0;
    #1;
    nChecks++;
    if (ifWt.dataR1 !== 32'h0 || ifNo.dataR1 !== 32'h0) begin
      nFails++; $display("FAIL x0_write_discarded: got %h %h expected %h", ifWt.dataR1, ifNo.dataR1, 32'h0);
    end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    rst_n = 1'b0; clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    RegWEn = 1'b1; rsW = 5'd6; rsR1 = 5'd6; rsR2 = 5'd6; dataW = 32'hCAFE_BABE;
    #1;
    nChecks++;
    if (ifWt.dataR1 !== 32'hCAFE_BABE || ifWt.dataR2 !== 32'hCAFE_BABE) begin
      nFails++; $display("FAIL hazard_wt_before_edge: got %h %h expected %h", ifWt.dataR1, ifWt.dataR2, 32'hCAFE_BABE);
    end
    nChecks++;
    if (ifNo.dataR1 !== 32'h0 || ifNo.dataR2 !== 32'h0) begin
      nFails++; $display("FAIL hazard_nowt_before_edge: got %h %h expected %h", ifNo.dataR1, ifNo.dataR2, 32'h0);
    end
    tick();
    RegWEn = 1'b0;
    #1;
    nChecks++;
    if (ifWt.dataR1 !== 32'hCAFE_BABE || ifNo.dataR1 !== 32'hCAFE_BABE) begin
      nFails++; $display("FAIL hazard_after_edge: got %h %h expected %h", ifWt.dataR1, ifNo.dataR1, 32'hCAFE_BABE);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    RegWEn = 1'b1; rsW = 5'd7; dataW = 32'hDEAD_BEEF; rsR1 = 5'd7; rsR2 = 5'd6;
    tick();
    RegWEn = 1'b0;
    #1;
    nChecks++;
    if (ifNo.dataR1 !== 32'hDEAD_BEEF) begin
      nFails++; $display("FAIL resetmid_prewrite: got %h expected %h", ifNo.dataR1, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    RegWEn = 1'b1; rsW = 5'd9; dataW = 32'h1111_2222;
    #2;
    rst_n = 1'b0; clearModel();
    #1;
    nChecks++;
    if (ifWt.dataR1 !== 32'h0 || ifNo.dataR1 !== 32'h0 || ifWt.dataR2 !== 32'h0) begin
      nFails++; $display("FAIL resetmid_immediate: got %h %h %h expected %h", ifWt.dataR1, ifNo.dataR1, ifWt.dataR2, 32'h0);
    end
    #1;
    rst_n = 1'b1; RegWEn = 1'b0;
    tick();
    nChecks++;
    if (ifWt.dataR1 !== 32'h0 || ifNo.dataR1 !== 32'h0) begin
      nFails++; $display("FAIL resetmid_after_edge: got %h %h expected %h", ifWt.dataR1, ifNo.dataR1, 32'h0);
    end
    rsR1 = 5'd9;
    #1;
    nChecks++;
    if (ifWt.dataR1 !== 32'h0 || ifNo.dataR1 !== 32'h0) begin
      nFails++; $display("FAIL resetmid_write_lost: got %h %h expected %h", ifWt.dataR1, ifNo.dataR1, 32'h0);
    end
  endtask

  task automatic test_random();
    word_t e1w, e2w, e1n, e2n;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      RegWEn = ($urandom_range(0, 3) != 0);
      rsW    = 5'($urandom_range(0, 31));
      dataW  = $urandom;
      rsR1   = ($urandom_range(0, 3) == 0) ? rsW : 5'($urandom_range(0, 31));
      rsR2   = ($urandom_range(0, 3) == 0) ? rsW : 5'($urandom_range(0, 31));
      if (c % 7 == 0) rsR2 = rsR1;
      #1;
      e1w = expRead(rsR1, 1'b1); e2w = expRead(rsR2, 1'b1);
      e1n = expRead(rsR1, 1'b0); e2n = expRead(rsR2, 1'b0);
      nChecks++;
      if (ifWt.dataR1 !== e1w || ifWt.dataR2 !== e2w || ifNo.dataR1 !== e1n || ifNo.dataR2 !== e2n) begin
        nFails++;
        $display("FAIL random_read cyc %0d r1=%0d r2=%0d w=%0d we=%b: got %h %h %h %h expected %h %h %h %h",
                 c, rsR1, rsR2, rsW, RegWEn, ifWt.dataR1, ifWt.dataR2, ifNo.dataR1, ifNo.dataR2,
                 e1w, e2w, e1n, e2n);
      end
      rsR1 = 5'($urandom_range(0, 31));
      #1;
      e1w = expRead(rsR1, 1'b1); e1n = expRead(rsR1, 1'b0);
      nChecks++;
      if (ifWt.dataR1 !== e1w || ifNo.dataR1 !== e1n) begin
        nFails++;
        $display("FAIL random_addr_change cyc %0d r1=%0d: got %h %h expected %h %h",
                 c, rsR1, ifWt.dataR1, ifNo.dataR1, e1w, e1n);
      end
      tick();
    end
    @(negedge clk);
    RegWEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rsR1 = 5'(i); rsR2 = 5'(i);
      #1;
      nChecks++;
      if (ifWt.dataR1 !== model[i] || ifNo.dataR2 !== model[i] || ifWt.dataR1 === 32'hx) begin
        nFails++;
        $display("FAIL final_sweep x%0d: got %h %h expected %h", i, ifWt.dataR1, ifNo.dataR2, model[i]);
      end
    end
  endtask

  initial begin
    nChecks = 0; nFails = 0;
    rst_n = 1'b1; RegWEn = 1'b0; rsR1 = '0; rsR2 = '0; rsW = '0; dataW = '0;
    clearModel();
    test_reset();
    test_basic_write();
    test_x0();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
